htif_sram_responder: RTL

Responder end of the HTIF request/response interface (htif_req_* in, htif_resp_* out). It serves the host debug/loader path from a local 64-bit on-chip SRAM window, so HTIF traffic can be brought up and checked without the core or DRAM. Requests are queued in a small FIFO and executed one per cycle. Every accepted request produces exactly one tagged response.

---
 rtl/libhtif_pkg.sv | 23 ++
 rtl/htif_req_fifo.sv | 47 ++++
 rtl/htif_sram_responder.sv | 139 +++++++++++++
 3 files changed

// File: rtl/libhtif_pkg.sv
// Shared HTIF definitions: opcodes, request record, error cause bit positions.
package libhtif;

  localparam logic [3:0] HTIF_OP_READ  = 4'd0;
  localparam logic [3:0] HTIF_OP_WRITE = 4'd1;

  // Bit positions inside error_cause
  localparam int ERR_ILLEGAL  = 0;
  localparam int ERR_MISALIGN = 1;
  localparam int ERR_RANGE    = 2;

  // SRAM word is split into byte lanes so byte enables map onto block RAM
  localparam int NUM_LANES = 8;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  wmask;
    logic [11:0] tag;
  } htif_req_t;

endpackage

// File: rtl/htif_req_fifo.sv
// Synchronous request queue; storage has no reset, only pointers and count do.
module htif_req_fifo import libhtif::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  htif_req_t                din,
  input  logic                     pop,
  output htif_req_t                dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  htif_req_t         mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Entry storage, written on accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally (DEPTH is a power of two); push+pop keeps count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/htif_sram_responder.sv
// HTIF responder backed by a local 64-bit SRAM window.
// Queue -> S1 (decode, SRAM access) -> S2 (registered response).
module htif_sram_responder import libhtif::*; #(
  parameter int          WORD_ADDR_BITS = 10,
  parameter int          FIFO_DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        htif_req_val,
  output logic        htif_req_rdy,
  input  logic [3:0]  htif_req_op,
  input  logic [31:0] htif_req_addr,
  input  logic [63:0] htif_req_data,
  input  logic [7:0]  htif_req_wmask,
  input  logic [11:0] htif_req_tag,
  output logic        htif_resp_val,
  output logic [63:0] htif_resp_data,
  output logic [11:0] htif_resp_tag,
  output logic        error,
  output logic [2:0]  error_cause
);

  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int WORDS = 1 << WORD_ADDR_BITS;
  localparam int HI    = WORD_ADDR_BITS + 3;  // first address bit above the window
  localparam logic [WORD_ADDR_BITS-1:0] BASE_IDX = BASE_ADDR[HI-1:3];

  htif_req_t           req_in, head;
  logic                push, pop;
  logic                fifo_full, fifo_empty;
  logic [CW-1:0]       fifo_count;

  assign push = htif_req_val && htif_req_rdy;
  assign pop  = !fifo_empty;

  // Pack the request fields into the queue record
  always_comb begin
    req_in       = '0;
    req_in.op    = htif_req_op;
    req_in.addr  = htif_req_addr;
    req_in.data  = htif_req_data;
    req_in.wmask = htif_req_wmask;
    req_in.tag   = htif_req_tag;
  end

  htif_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (req_in),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Ready tracks the next count so it is registered yet never stale;
  // a push cannot happen while full, so only pop frees a slot there.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) htif_req_rdy <= 1'b0;
    else      htif_req_rdy <= !((fifo_full && !pop) ||
                                (fifo_count == CW'(FIFO_DEPTH - 1) && push && !pop));
  end

  // ---- S1 decode ----
  logic                      mis, oow, ill, bad, wr_en, rd_en;
  logic [WORD_ADDR_BITS-1:0] widx;

  assign mis   = head.addr[2:0] != 3'b000;
  assign oow   = head.addr[31:HI] != BASE_ADDR[31:HI];
  assign ill   = (head.op != HTIF_OP_READ) && (head.op != HTIF_OP_WRITE);
  assign bad   = mis || oow || ill;
  assign widx  = head.addr[HI-1:3] - BASE_IDX;
  assign wr_en = pop && !bad && (head.op == HTIF_OP_WRITE);
  assign rd_en = pop && !bad && (head.op == HTIF_OP_READ);

  // ---- SRAM: one byte-wide RAM per lane, single op per cycle ----
  logic [NUM_LANES-1:0][7:0] rd_lane;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [7:0] mem [WORDS];
    logic [7:0] q;
    // Byte write on its enable, synchronous read; never both in one cycle
    always_ff @(posedge clk) begin
      if (wr_en && head.wmask[l]) mem[widx] <= head.data[8*l +: 8];
      if (rd_en)                  q <= mem[widx];
    end
    assign rd_lane[l] = q;
  end

  // ---- S1 -> S2 pipeline ----
  logic [2:1]  vld_pipe;
  logic        s1_rd;
  logic [11:0] s1_tag;

  // Carry valid and response context alongside the SRAM read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      s1_rd    <= 1'b0;
      s1_tag   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], pop};
      if (pop) begin
        s1_rd  <= rd_en;
        s1_tag <= head.tag;
      end
    end
  end

  assign htif_resp_val = vld_pipe[2];

  // Response payload; holds its last value between responses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      htif_resp_data <= '0;
      htif_resp_tag  <= '0;
    end else if (vld_pipe[1]) begin
      htif_resp_data <= s1_rd ? rd_lane : 64'd0;
      htif_resp_tag  <= s1_tag;
    end
  end

  // Sticky error flags, set as a bad request is issued
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      error       <= 1'b0;
      error_cause <= '0;
    end else if (pop) begin
      error                    <= error | bad;
      error_cause[ERR_ILLEGAL]  <= error_cause[ERR_ILLEGAL]  | ill;
      error_cause[ERR_MISALIGN] <= error_cause[ERR_MISALIGN] | mis;
      error_cause[ERR_RANGE]    <= error_cause[ERR_RANGE]    | oow;
    end
  end

endmodule
